// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: datapath width, bubble encoding
// and the instruction-fetch FSM state type.
package pipeline_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [31:0]     rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, flush-to-bubble, or hold; async active-low reset.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;

    // Flush wins over load so a redirect can never let a stale word through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem handshake and a one-word
// hold buffer, and feeds the IF/ID register consumed by decode.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0]     NOP      = NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pc_enable,
    input  logic               if_id_enable,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    pc_branch_value,
    fetch_stage_if.master      imem,
    output logic [31:0]        instruction,
    output logic [XLEN-1:0]    pc,
    output logic               valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [31:0]     hold_q, hold_d;

    logic            stall, redirect, avail;
    logic            ifid_load, ifid_flush;
    logic [31:0]     word;
    logic [XLEN-1:0] target;

    assign stall    = !(pc_enable && if_id_enable);
    assign redirect = branch_taken && !stall;
    assign avail    = ((state_q == ST_FETCH) && imem.ready) || (state_q == ST_HOLD);
    assign word     = (state_q == ST_HOLD) ? hold_q : imem.rdata;
    assign target   = pc_branch_value & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_START;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            hold_q       <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        hold_d       = hold_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;

        if (state_q == ST_DISCARD) begin
            // The outstanding response belongs to a dead path; refetch from the live PC once it lands.
            if (redirect) pc_d = target;
            ifid_flush = redirect || if_id_enable;
            if (imem.ready) begin
                fetch_addr_d = redirect ? target : pc_q;
                state_d      = ST_FETCH;
            end
        end else if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
            if ((state_q == ST_FETCH) && !imem.ready) begin
                state_d = ST_DISCARD;
            end else begin
                fetch_addr_d = target;
                state_d      = ST_FETCH;
            end
        end else if (avail && !stall) begin
            ifid_load    = 1'b1;
            pc_d         = pc_q + XLEN'(4);
            fetch_addr_d = pc_q + XLEN'(4);
            state_d      = ST_FETCH;
        end else if (avail) begin
            if (state_q == ST_FETCH) hold_d = imem.rdata;
            state_d = ST_HOLD;
        end else if (state_q == ST_FETCH) begin
            ifid_flush = if_id_enable;
        end else begin
            state_d = ST_FETCH;
        end
    end

    assign imem.req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem.addr = fetch_addr_q;

    if_id_reg #(
        .XLEN (XLEN),
        .NOP  (NOP)
    ) u_if_id (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (word),
        .pc_i    (pc_q),
        .instr_o (instruction),
        .pc_o    (pc),
        .valid_o (valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory and
// checks the IF/ID outputs and imem handshake cycle by cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        pc_enable;
    logic        if_id_enable;
    logic        branch_taken;
    logic [31:0] pc_branch_value;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        valid;
    logic        mem_block;

    int n_checks;
    int n_fail;

    fetch_stage_if #(.XLEN(32)) imem_bus ();

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .pc_enable       (pc_enable),
        .if_id_enable    (if_id_enable),
        .branch_taken    (branch_taken),
        .pc_branch_value (pc_branch_value),
        .imem            (imem_bus),
        .instruction     (instruction),
        .pc              (pc),
        .valid           (valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0093;
            32'h4:   return 32'h0010_0113;
            default: return {a[19:0], 12'h013};
        endcase
    endfunction

    assign imem_bus.ready = imem_bus.req && !mem_block;
    assign imem_bus.rdata = mem_word(imem_bus.addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] epc, input logic evalid);
        check({tag, "_valid"}, {31'b0, valid}, {31'b0, evalid});
        check({tag, "_pc"}, pc, epc);
        check({tag, "_instr"}, instruction, evalid ? mem_word(epc) : NOPW);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; pc_enable = 1'b1; if_id_enable = 1'b1;
        branch_taken = 1'b0; pc_branch_value = '0; mem_block = 1'b0;

        step();
        check("rst_req", {31'b0, imem_bus.req}, 32'd0);
        check_ifid("rst", 32'h0, 1'b0);
        reset = 1'b1;

        // Test 1: zero-wait fetch
        step();
        check("t1_req", {31'b0, imem_bus.req}, 32'd1);
        check("t1_addr0", imem_bus.addr, 32'h0);
        step();
        check_ifid("t1_i0", 32'h0, 1'b1);
        check("t1_addr4", imem_bus.addr, 32'h4);
        step();
        check_ifid("t1_i1", 32'h4, 1'b1);
        check("t1_addr8", imem_bus.addr, 32'h8);

        // Test 2: two-cycle stall while word at 0x8 returns
        pc_enable = 1'b0; if_id_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t2_hold_pc", pc, 32'h4);
            check("t2_hold_req", {31'b0, imem_bus.req}, 32'd0);
        end
        pc_enable = 1'b1; if_id_enable = 1'b1;
        step();
        check_ifid("t2_i8", 32'h8, 1'b1);
        check("t2_addrC", imem_bus.addr, 32'hC);

        // Test 3: redirect to 0x40
        branch_taken = 1'b1; pc_branch_value = 32'h40;
        step();
        branch_taken = 1'b0;
        check_ifid("t3_bubble", 32'h0, 1'b0);
        check("t3_addr40", imem_bus.addr, 32'h40);
        step();
        check_ifid("t3_i40", 32'h40, 1'b1);

        // Test 4: three wait cycles on 0x10
        branch_taken = 1'b1; pc_branch_value = 32'h10;
        step();
        branch_taken = 1'b0; mem_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_addr", imem_bus.addr, 32'h10);
            check("t4_bubble", {31'b0, valid}, 32'd0);
        end
        mem_block = 1'b0;
        step();
        check_ifid("t4_i10", 32'h10, 1'b1);

        // Test 5: redirect while 0x10 is outstanding
        branch_taken = 1'b1; pc_branch_value = 32'h10;
        step();
        branch_taken = 1'b0; mem_block = 1'b1;
        step();
        check("t5_pend_addr", imem_bus.addr, 32'h10);
        branch_taken = 1'b1; pc_branch_value = 32'h80;
        step();
        branch_taken = 1'b0;
        check("t5_disc_addr", imem_bus.addr, 32'h10);
        check("t5_disc_req", {31'b0, imem_bus.req}, 32'd1);
        check("t5_disc_valid", {31'b0, valid}, 32'd0);
        step();
        check("t5_disc2_addr", imem_bus.addr, 32'h10);
        check("t5_disc2_valid", {31'b0, valid}, 32'd0);
        mem_block = 1'b0;
        step();
        check("t5_addr80", imem_bus.addr, 32'h80);
        check("t5_drop_valid", {31'b0, valid}, 32'd0);
        step();
        check_ifid("t5_i80", 32'h80, 1'b1);

        // Test 6: branch ignored under stall, then async reset mid-fetch
        branch_taken = 1'b1; pc_branch_value = 32'h200; if_id_enable = 1'b0;
        step();
        check_ifid("t6_stall", 32'h80, 1'b1);
        check("t6_stall_req", {31'b0, imem_bus.req}, 32'd0);
        branch_taken = 1'b0; if_id_enable = 1'b1;
        step();
        check_ifid("t6_i84", 32'h84, 1'b1);
        check("t6_addr88", imem_bus.addr, 32'h88);
        reset = 1'b0;
        #1;
        check("t6_rst_req", {31'b0, imem_bus.req}, 32'd0);
        check_ifid("t6_rst", 32'h0, 1'b0);
        step();
        check("t6_rst_req2", {31'b0, imem_bus.req}, 32'd0);
        reset = 1'b1;
        step();
        check("t6_req", {31'b0, imem_bus.req}, 32'd1);
        check("t6_addr0", imem_bus.addr, 32'h0);
        step();
        check_ifid("t6_i0", 32'h0, 1'b1);

        // Misaligned branch target is forced to a word boundary
        branch_taken = 1'b1; pc_branch_value = 32'h102;
        step();
        branch_taken = 1'b0;
        check("mis_addr", imem_bus.addr, 32'h100);
        step();
        check_ifid("mis_i100", 32'h100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage RV32I pipeline. It produces the `instruction`/`pc` pair consumed by the `decode` stage through the IF/ID register. It owns the PC and the handshake with instruction memory. It obeys the stall enables (`pc_enable`, `if_id_enable`) from the decode hazard unit and the branch redirect (`branch_taken`, `pc_branch_value`) resolved in ID.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h00000000, PC loaded on reset
NOP, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush or empty fetch

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
pc_enable  in  1  from decode hazard unit; 0 = stall PC
if_id_enable  in  1  from decode hazard unit; 0 = hold IF/ID register
branch_taken  in  1  branch resolved taken in ID this cycle
pc_branch_value  in  XLEN  branch target from ID
imem_req  out  1  instruction-memory request valid
imem_addr  out  XLEN  word-aligned fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  read data valid for the outstanding request; ignored when imem_req=0
imem_rdata  in  32  instruction word, valid when imem_ready=1
instruction  out  32  IF/ID instruction to decode
pc  out  XLEN  IF/ID PC to decode
valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (reset=0, async): state=START, pc_reg=RESET_PC, fetch_addr=RESET_PC, imem_req=0, instruction=NOP, pc=0, valid=0, hold buffer empty.
- Definitions:
  - stall = !(pc_enable && if_id_enable); both enables must be 1 to advance.
  - redirect = branch_taken && !stall. When stall=1, branch_taken is ignored; ID re-asserts it after the stall.
  - avail = (state==FETCH && imem_ready) || state==HOLD. The instruction comes from imem_rdata or from the hold buffer.
- FSM states:
  - START: imem_req=0. Go to FETCH next cycle. Gives one idle cycle after reset release.
  - FETCH: imem_req=1, imem_addr=fetch_addr.
  - HOLD: imem_req=0. The fetched word sits in the hold buffer.
  - DISCARD: imem_req=1 with the old fetch_addr. Waits for imem_ready, then drops the data.
- Transitions, evaluated in priority order:
  1. redirect:
     - pc_reg<=pc_branch_value; IF/ID<= {NOP, 0, valid=0}.
     - From FETCH with imem_ready=0: go to DISCARD; fetch_addr is unchanged.
     - Otherwise: fetch_addr<=pc_branch_value; go to FETCH.
  2. avail && !stall:
     - IF/ID<= {word, pc_reg, valid=1}.
     - pc_reg<=pc_reg+4 and fetch_addr<=pc_reg+4 (mod 2^XLEN, wraps silently).
     - Go to FETCH.
  3. avail && stall: capture the word into the hold buffer if coming from FETCH; go to or stay in HOLD. IF/ID and PC hold.
  4. FETCH && !imem_ready: stay in FETCH. If if_id_enable=1, IF/ID<= {NOP, 0, valid=0} (bubble); else IF/ID holds.
  5. DISCARD: when imem_ready=1, fetch_addr<=pc_reg and go to FETCH; otherwise stay. IF/ID loads a bubble when if_id_enable=1. A redirect while in DISCARD only updates pc_reg.
- Latency: one cycle from imem_ready to IF/ID output. With zero-wait memory, throughput is one instruction per cycle.
- Guarantees: no instruction is duplicated or skipped across stalls. No word fetched before a redirect ever reaches IF/ID with valid=1. imem_addr[1:0] is always 0; a misaligned pc_branch_value is forced to a word boundary by clearing bits [1:0].
- Reset asserted mid-transaction: all state clears immediately. Any pending memory response is not tracked; the memory sees imem_req drop.

Decomposition:
- Shared package `pipeline_pkg`: XLEN, NOP_INSTR, RESET_PC default, and the fetch FSM state enum (START, FETCH, HOLD, DISCARD). `decode` and later stages reuse XLEN and NOP_INSTR.
- One sub-module: `if_id_reg`, the IF/ID pipeline register. It has load, flush (loads NOP/valid=0), hold, and async active-low reset.
- The FSM, PC, fetch_addr and hold buffer stay in `fetch_stage`.

Test Plan:
1. Release reset with zero-wait memory returning 0x00000093 at 0x0 and 0x00100113 at 0x4. Required: imem_addr is 0x0 then 0x4 on consecutive cycles. The cycle after each handshake, instruction=0x00000093/pc=0x0/valid=1, then 0x00100113/pc=0x4/valid=1.
2. Drive pc_enable=if_id_enable=0 for 2 cycles while the word at 0x8 returns. Required: IF/ID holds pc=0x4 and state is HOLD. After release, pc=0x8 appears exactly once, followed by pc=0xC.
3. At IF/ID pc=0x8, assert branch_taken=1 with pc_branch_value=0x40. Required: next cycle instruction=0x00000013 and valid=0; imem_addr=0x40; the cycle after, pc=0x40 with valid=1.
4. imem_ready delayed 3 cycles at 0x10. Required: imem_addr holds 0x10, IF/ID shows 3 bubbles (valid=0), then instruction pc=0x10.
5. Request at 0x10 pending, then redirect to 0x80. Required: imem_addr stays 0x10 until imem_ready (DISCARD), then 0x80. No valid output ever carries pc=0x10.
6. branch_taken=1 together with if_id_enable=0, then assert reset=0 while in FETCH. Required: the branch is ignored during the stall. On reset, imem_req=0, valid=0, instruction=0x00000013 immediately (asynchronously). First fetch after release is from 0x0.
